// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Optional feature macro: WB_BYPASS_EN (see regfile_wb_arbiter).
package wb_pkg;

    // Arbiter priority state: MEM wins by default, ALU wins once starved.
    typedef enum logic {
        PRIO_MEM = 1'b0,
        PRIO_ALU = 1'b1
    } wb_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int         ADDR_W   = 5;
    localparam int         DATA_W   = 32;

    // Wait counter width; covers the legal WAIT_MAX range 1..15.
    localparam int         CNT_W    = 4;

endpackage

// File: rtl/wb_age_counter.sv
// Saturating age counter: counts blocked cycles of a requester.
// hold has priority over clr, clr has priority over inc.
module wb_age_counter
    import wb_pkg::*;
#(
    parameter int MAX = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    input  logic             hold,
    output logic [CNT_W-1:0] cnt,
    output logic             sat
);

    assign sat = (cnt == CNT_W'(MAX));

    // Count up to MAX and stick there; a frozen pipeline freezes the age too.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (hold) begin
            cnt <= cnt;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !sat) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: shares one write port between the
// ALU result path and the memory-load path. MEM has fixed priority; an
// ALU request blocked for WAIT_MAX cycles gets one forced grant.
// Writes to register 0 complete the handshake but never assert WrEn.
// Optional macro WB_BYPASS_EN adds decode-stage forwarding outputs.
module regfile_wb_arbiter #(
    parameter int WAIT_MAX = 4,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Stall,
    input  logic              Alu_Vld,
    output logic              Alu_Rdy,
    input  logic [ADDR_W-1:0] Alu_Addr,
    input  logic [DATA_W-1:0] Alu_Data,
    input  logic              Mem_Vld,
    output logic              Mem_Rdy,
    input  logic [ADDR_W-1:0] Mem_Addr,
    input  logic [DATA_W-1:0] Mem_Data,
    output logic [ADDR_W-1:0] Awr,
    output logic [DATA_W-1:0] Din,
    output logic              WrEn,
`ifdef WB_BYPASS_EN
    input  logic [ADDR_W-1:0] Ard1,
    input  logic [ADDR_W-1:0] Ard2,
    output logic              Byp1,
    output logic              Byp2,
    output logic [DATA_W-1:0] Byp_Data,
`endif
    output logic              Alu_Starved
);

    import wb_pkg::*;

    wb_state_e        state;
    logic             alu_rdy;
    logic             mem_rdy;
    logic             alu_acc;
    logic             mem_acc;
    logic             cnt_inc;
    logic             cnt_clr;
    logic             to_alu;
    logic [CNT_W-1:0] wait_cnt;
    logic             wait_sat;

    // Grant decode: the favoured side gets Rdy whenever not stalled, the
    // other side only when the favoured side is idle, so at most one accepts.
    always_comb begin
        alu_rdy = 1'b0;
        mem_rdy = 1'b0;
        if (!Rst && !Stall) begin
            if (state == PRIO_ALU) begin
                alu_rdy = 1'b1;
                mem_rdy = !Alu_Vld;
            end else begin
                mem_rdy = 1'b1;
                alu_rdy = !Mem_Vld;
            end
        end
    end

    assign Alu_Rdy     = alu_rdy;
    assign Mem_Rdy     = mem_rdy;
    assign alu_acc     = Alu_Vld & alu_rdy;
    assign mem_acc     = Mem_Vld & mem_rdy;
    assign Alu_Starved = (state == PRIO_ALU);

    assign cnt_inc = Alu_Vld & !alu_rdy & !Stall;
    assign cnt_clr = alu_acc | !Alu_Vld;

    // Switch priority on the same edge the counter reaches WAIT_MAX, so the
    // ALU is granted in the cycle right after its WAIT_MAX-th blocked cycle.
    assign to_alu = Alu_Vld &
                    (wait_sat | (cnt_inc & (wait_cnt == CNT_W'(WAIT_MAX - 1))));

    wb_age_counter #(
        .MAX (WAIT_MAX)
    ) u_age (
        .clk  (Clk),
        .rst  (Rst),
        .inc  (cnt_inc),
        .clr  (cnt_clr),
        .hold (Stall),
        .cnt  (wait_cnt),
        .sat  (wait_sat)
    );

    // Priority FSM; frozen while stalled. PRIO_ALU lasts until the ALU is
    // accepted or drops its request.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= PRIO_MEM;
        end else if (!Stall) begin
            case (state)
                PRIO_MEM: if (to_alu) state <= PRIO_ALU;
                PRIO_ALU: if (alu_acc || !Alu_Vld) state <= PRIO_MEM;
                default:  state <= PRIO_MEM;
            endcase
        end
    end

    // Registered write port: latch the accepted request; register 0 updates
    // Awr/Din but keeps WrEn low. No accept keeps Awr/Din and drops WrEn.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            WrEn <= 1'b0;
            Awr  <= '0;
            Din  <= '0;
        end else if (mem_acc) begin
            WrEn <= (Mem_Addr != ADDR_W'(REG_ZERO));
            Awr  <= Mem_Addr;
            Din  <= Mem_Data;
        end else if (alu_acc) begin
            WrEn <= (Alu_Addr != ADDR_W'(REG_ZERO));
            Awr  <= Alu_Addr;
            Din  <= Alu_Data;
        end else begin
            WrEn <= 1'b0;
        end
    end

`ifdef WB_BYPASS_EN
    // Forward the write landing this cycle to the decode-stage readers.
    assign Byp1     = WrEn & (Awr == Ard1) & (Awr != ADDR_W'(REG_ZERO));
    assign Byp2     = WrEn & (Awr == Ard2) & (Awr != ADDR_W'(REG_ZERO));
    assign Byp_Data = Din;
`endif

endmodule
